// File: rtl/fft_output_streamer_if.sv
`timescale 1ns/1ps
// Bus bundle for fft_output_streamer: control, memory read port and output stream.
interface fft_output_streamer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic [ADDR_W-1:0] m_index;

   modport master (
      input  start, mem_rd_data, m_ready,
      output busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last, m_index
   );

   modport slave (
      output start, mem_rd_data, m_ready,
      input  busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last, m_index
   );
endinterface

// File: rtl/fft_output_streamer.sv
`timescale 1ns/1ps
// Unloads one N-word frame from the FFT memory's synchronous read port into a
// valid/ready stream through a 2-entry skid FIFO, optionally in bit-reversed read order.
module fft_output_streamer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int BITREV = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   fft_output_streamer_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] index;
      logic              last;
   } beat_t;

   state_t            state;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] issue_cnt;
   logic [ADDR_W-1:0] inflight_idx;
   logic              inflight;
   beat_t             fifo_mem [2];
   beat_t             head;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ;
   logic [2:0]        pending;
   logic              valid;
   logic              pop;
   logic              push;
   logic              issue;

   function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] v);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
      return r;
   endfunction

   assign head  = fifo_mem[rd_ptr];
   assign valid = (occ != 2'd0);
   assign pop   = valid & bus.m_ready;
   assign push  = inflight;

   // Slots already committed next cycle: held entries plus the word in flight, minus the one leaving now.
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue   = (state == RUN) && (pending < 3'd2);

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mem_rd_en   = issue;
   assign bus.mem_rd_addr = (BITREV != 0) ? bit_reverse(issue_cnt) : issue_cnt;
   assign bus.m_valid     = valid;
   assign bus.m_data      = valid ? head.data  : '0;
   assign bus.m_last      = valid & head.last;
   assign bus.m_index     = valid ? head.index : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               if (issue && (issue_cnt == LAST_IDX)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && head.last) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight     <= 1'b0;
         issue_cnt    <= '0;
         inflight_idx <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            issue_cnt    <= issue_cnt + 1'b1;
            inflight_idx <= issue_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         occ <= occ + {1'b0, push} - {1'b0, pop};
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   // NOTE: the FIFO storage is deliberately not reset; occ gates every read of it
   // and the outputs are forced to zero whenever it is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{data: bus.mem_rd_data, index: inflight_idx,
                               last: (inflight_idx == LAST_IDX)};
      end
   end

endmodule

// File: tb/tb_fft_output_streamer.sv
`timescale 1ns/1ps
// Directed bench for fft_output_streamer: one linear and one bit-reversed instance,
// each fed from a synchronous-read memory preloaded with 32'hA500_0000 | address.
module tb_fft_output_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   fft_output_streamer_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
   fft_output_streamer_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

   fft_output_streamer #(.ADDR_W(8), .DATA_W(32), .BITREV(0)) dut_lin (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   fft_output_streamer #(.ADDR_W(8), .DATA_W(32), .BITREV(1)) dut_rev (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Synchronous-read memory models: data appears the cycle after mem_rd_en, held otherwise.
   always @(posedge clk) begin
      if (!rst_n)              bus0.mem_rd_data <= '0;
      else if (bus0.mem_rd_en) bus0.mem_rd_data <= mem[bus0.mem_rd_addr];
   end

   always @(posedge clk) begin
      if (!rst_n)              bus1.mem_rd_data <= '0;
      else if (bus1.mem_rd_en) bus1.mem_rd_data <= mem[bus1.mem_rd_addr];
   end

   function automatic logic [31:0] word_of(input int i);
      return 32'hA500_0000 | 32'(i);
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic step0(input logic st, input logic rdy);
      @(negedge clk);
      bus0.start   = st;
      bus0.m_ready = rdy;
      #1;
   endtask

   task automatic test_reset;
      logic [4:0] got;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
      checks++;
      if (got !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000", got);
      end
      checks++;
      if (bus0.mem_rd_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_addr got %h want 00", bus0.mem_rd_addr);
      end
      got = {bus1.busy, bus1.done, bus1.mem_rd_en, bus1.m_valid, bus1.m_last};
      checks++;
      if (got !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags_rev got %b want 00000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step0(1'b0, 1'b0);
      got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
      checks++;
      if (got !== 5'b0 || bus0.m_data !== 32'h0) begin
         errors++;
         $display("FAIL post_reset_flags got %b data %h want 00000 data 0", got, bus0.m_data);
      end
   endtask

   // flags = {busy, done, mem_rd_en, m_valid, m_last}
   task automatic test_full_speed;
      logic [4:0] got;
      logic [4:0] exp;
      for (int c = 0; c <= 262; c++) begin
         step0(c == 0, 1'b1);
         exp = {(c >= 1 && c <= 258), (c == 259), (c >= 1 && c <= 256),
                (c >= 3 && c <= 258), (c == 258)};
         got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL full_flags cycle %0d got %b want %b", c, got, exp);
         end
         if (c >= 1 && c <= 256) begin
            checks++;
            if (bus0.mem_rd_addr !== 8'(c - 1)) begin
               errors++;
               $display("FAIL full_addr cycle %0d got %h want %h", c, bus0.mem_rd_addr, 8'(c - 1));
            end
         end
         if (c >= 3 && c <= 258) begin
            checks++;
            if (bus0.m_data !== word_of(c - 3) || bus0.m_index !== 8'(c - 3)) begin
               errors++;
               $display("FAIL full_beat cycle %0d got %h/%h want %h/%h", c, bus0.m_data,
                        bus0.m_index, word_of(c - 3), 8'(c - 3));
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int          beats = 0;
      int          reads = 0;
      int          occ_m = 0;
      int          infl_m = 0;
      logic        done_seen = 1'b0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic [7:0]  prev_idx = '0;
      logic        prev_last = 1'b0;
      logic        rdy;
      logic        pop;
      step0(1'b1, 1'b0);
      for (int c = 1; c <= 3000 && !done_seen; c++) begin
         rdy = (c >= 100 && c < 110) ? 1'b0 : 1'($urandom_range(1, 0));
         step0(1'b0, rdy);
         pop = bus0.m_valid & rdy;
         checks++;
         if (bus0.m_valid !== (occ_m != 0) || (occ_m + infl_m) > 2) begin
            errors++;
            $display("FAIL bp_occupancy cycle %0d valid %b model_occ %0d inflight %0d",
                     c, bus0.m_valid, occ_m, infl_m);
         end
         if (prev_stall) begin
            checks++;
            if (bus0.m_valid !== 1'b1 || bus0.m_data !== prev_data ||
                bus0.m_index !== prev_idx || bus0.m_last !== prev_last) begin
               errors++;
               $display("FAIL bp_stall_stable cycle %0d got %b %h/%h want 1 %h/%h", c,
                        bus0.m_valid, bus0.m_data, bus0.m_index, prev_data, prev_idx);
            end
         end
         if (pop) begin
            checks++;
            if (bus0.m_data !== word_of(beats) || bus0.m_index !== 8'(beats) ||
                bus0.m_last !== (beats == 255)) begin
               errors++;
               $display("FAIL bp_beat %0d got %h/%h last %b want %h/%h", beats, bus0.m_data,
                        bus0.m_index, bus0.m_last, word_of(beats), 8'(beats));
            end
            beats++;
         end
         if (bus0.mem_rd_en) begin
            checks++;
            if (reads > 255 || bus0.mem_rd_addr !== 8'(reads)) begin
               errors++;
               $display("FAIL bp_read %0d got addr %h want %h", reads, bus0.mem_rd_addr, 8'(reads));
            end
            reads++;
         end
         if (bus0.done) begin
            done_seen = 1'b1;
            checks++;
            if (beats != 256 || bus0.busy !== 1'b0) begin
               errors++;
               $display("FAIL bp_done got beats %0d busy %b want 256 0", beats, bus0.busy);
            end
         end
         occ_m      = occ_m + infl_m - (pop ? 1 : 0);
         infl_m     = bus0.mem_rd_en ? 1 : 0;
         prev_stall = bus0.m_valid & ~rdy;
         prev_data  = bus0.m_data;
         prev_idx   = bus0.m_index;
         prev_last  = bus0.m_last;
      end
      checks++;
      if (!done_seen || reads != 256) begin
         errors++;
         $display("FAIL bp_complete got done %b reads %0d beats %0d want 1 256 256",
                  done_seen, reads, beats);
      end
      step0(1'b0, 1'b1);
      checks++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.m_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_after got done %b busy %b valid %b want 0 0 0",
                  bus0.done, bus0.busy, bus0.m_valid);
      end
   endtask

   task automatic test_bitrev;
      logic [4:0]  got;
      logic [4:0]  exp;
      logic [31:0] want;
      for (int c = 0; c <= 261; c++) begin
         @(negedge clk);
         bus1.start   = (c == 0);
         bus1.m_ready = 1'b1;
         #1;
         exp = {(c >= 1 && c <= 258), (c == 259), (c >= 1 && c <= 256),
                (c >= 3 && c <= 258), (c == 258)};
         got = {bus1.busy, bus1.done, bus1.mem_rd_en, bus1.m_valid, bus1.m_last};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rev_flags cycle %0d got %b want %b", c, got, exp);
         end
         if (c >= 1 && c <= 256) begin
            checks++;
            if (bus1.mem_rd_addr !== rev8(8'(c - 1))) begin
               errors++;
               $display("FAIL rev_addr cycle %0d got %h want %h", c, bus1.mem_rd_addr, rev8(8'(c - 1)));
            end
         end
         if (c >= 3 && c <= 258) begin
            want = word_of(int'(rev8(8'(c - 3))));
            checks++;
            if (bus1.m_data !== want || bus1.m_index !== 8'(c - 3)) begin
               errors++;
               $display("FAIL rev_beat %0d got %h/%h want %h/%h", c - 3, bus1.m_data,
                        bus1.m_index, want, 8'(c - 3));
            end
         end
         if (c == 3 || c == 4 || c == 5 || c == 258) begin
            want = (c == 3) ? 32'hA500_0000 : (c == 4) ? 32'hA500_0080 :
                   (c == 5) ? 32'hA500_0040 : 32'hA500_00FF;
            checks++;
            if (bus1.m_data !== want) begin
               errors++;
               $display("FAIL rev_landmark beat %0d got %h want %h", c - 3, bus1.m_data, want);
            end
         end
      end
   endtask

   // Start pulses in RUN (50) and DRAIN (257, 258) are ignored; the one in the done cycle (259) starts frame 2.
   task automatic test_start_ignored;
      logic [3:0] got;
      logic [3:0] exp;
      logic       st;
      int         k;
      int         exp_idx;
      int         exp_addr;
      for (int c = 0; c <= 521; c++) begin
         st = (c == 0 || c == 50 || c == 257 || c == 258 || c == 259);
         step0(st, 1'b1);
         exp      = 4'b0;
         exp_idx  = 0;
         exp_addr = 0;
         for (int f = 0; f < 2; f++) begin
            k = c - f * 259;
            if (k >= 1 && k <= 258) exp[3] = 1'b1;
            if (k == 259)           exp[2] = 1'b1;
            if (k >= 1 && k <= 256) begin
               exp[1]   = 1'b1;
               exp_addr = k - 1;
            end
            if (k >= 3 && k <= 258) begin
               exp[0]  = 1'b1;
               exp_idx = k - 3;
            end
         end
         got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL start_flags cycle %0d got %b want %b", c, got, exp);
         end
         if (exp[1]) begin
            checks++;
            if (bus0.mem_rd_addr !== 8'(exp_addr)) begin
               errors++;
               $display("FAIL start_addr cycle %0d got %h want %h", c, bus0.mem_rd_addr, 8'(exp_addr));
            end
         end
         if (exp[0]) begin
            checks++;
            if (bus0.m_data !== word_of(exp_idx) || bus0.m_index !== 8'(exp_idx)) begin
               errors++;
               $display("FAIL start_beat cycle %0d got %h/%h want %h/%h", c, bus0.m_data,
                        bus0.m_index, word_of(exp_idx), 8'(exp_idx));
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [4:0] got;
      logic [4:0] exp;
      for (int c = 0; c <= 102; c++) step0(c == 0, 1'b1);
      @(negedge clk);
      rst_n        = 1'b0;
      bus0.m_ready = 1'b1;
      #1;
      checks++;
      if (bus0.m_valid !== 1'b1 || bus0.m_index !== 8'd100 || bus0.m_data !== word_of(100)) begin
         errors++;
         $display("FAIL mid_beat100 got %b %h/%h want 1 %h/64", bus0.m_valid, bus0.m_data,
                  bus0.m_index, word_of(100));
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
      checks++;
      if (got !== 5'b0 || bus0.mem_rd_addr !== 8'h00 || bus0.m_data !== 32'h0 ||
          bus0.m_index !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_outputs got %b addr %h data %h idx %h want all 0", got,
                  bus0.mem_rd_addr, bus0.m_data, bus0.m_index);
      end
      for (int c = 0; c < 20; c++) begin
         step0(1'b0, 1'b1);
         got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
         checks++;
         if (got !== 5'b0) begin
            errors++;
            $display("FAIL mid_quiet cycle %0d got %b want 00000", c, got);
         end
      end
      for (int c = 0; c <= 260; c++) begin
         step0(c == 0, 1'b1);
         exp = {(c >= 1 && c <= 258), (c == 259), (c >= 1 && c <= 256),
                (c >= 3 && c <= 258), (c == 258)};
         got = {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.m_valid, bus0.m_last};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mid_restart_flags cycle %0d got %b want %b", c, got, exp);
         end
         if (c >= 3 && c <= 258) begin
            checks++;
            if (bus0.m_data !== word_of(c - 3) || bus0.m_index !== 8'(c - 3)) begin
               errors++;
               $display("FAIL mid_restart_beat cycle %0d got %h/%h want %h/%h", c, bus0.m_data,
                        bus0.m_index, word_of(c - 3), 8'(c - 3));
            end
         end
      end
   endtask

   initial begin
      bus0.start   = 1'b0;
      bus0.m_ready = 1'b0;
      bus1.start   = 1'b0;
      bus1.m_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = word_of(i);
      test_reset();
      test_full_speed();
      test_backpressure();
      test_bitrev();
      test_start_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
